hypot_sched: RTL and testbench

Shared, multi-cycle hypotenuse engine with a two-requester round-robin front end. The block arbitrates between two valid/ready request ports and squares and sums the granted X/Y pair. It then computes floor(sqrt(X²+Y²)) with a digit-by-digit (restoring) square root, one result bit per cycle, and returns the root with the requester ID on a valid/ready response port. It replaces per-requester combinational sqrt logic with one time-shared iterative datapath plus its sequencing FSM.

---
 rtl/hypot_sched.sv | 190 +++++++++++++++++++
 tb/tb_hypot_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hypot_sched.sv
// hypot_sched: shared iterative hypotenuse engine with a two-requester
// round-robin front end.
//
// A granted X/Y pair is squared and summed into a 2W+2-bit radicand. The
// engine then extracts floor(sqrt(radicand)) with a restoring digit-by-digit
// square root, one root bit per cycle, and returns the root plus the
// requester id on a valid/ready response port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[1:0]        per-requester request valid
//   req_ready[1:0]        per-requester accept (at most one high, IDLE only)
//   req_x0/req_y0         operands, requester 0
//   req_x1/req_y1         operands, requester 1
//   rsp_valid/rsp_ready   response handshake
//   rsp_root              floor(sqrt(X^2+Y^2)), W+1 bits
//   rsp_exact             radicand is a perfect square
//   rsp_id                requester that issued the result
//   busy                  engine is not IDLE

// Per-requester slice: decides whether this port is the one being accepted
// and presents its operand pair.
module hypot_sched_port #(
  parameter int W   = 8,
  parameter int IDX = 0
) (
  input  logic           idle_i,
  input  logic           valid_i,
  input  logic           gnt_id_i,
  input  logic [W-1:0]   x_i,
  input  logic [W-1:0]   y_i,
  output logic           ready_o,
  output logic [2*W-1:0] op_o
);
  assign ready_o = idle_i & valid_i & (gnt_id_i == 1'(IDX));
  assign op_o    = {x_i, y_i};
endmodule

module hypot_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_x0,
  input  logic [W-1:0] req_y0,
  input  logic [W-1:0] req_x1,
  input  logic [W-1:0] req_y1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W:0]   rsp_root,
  output logic         rsp_exact,
  output logic         rsp_id,
  output logic         busy
);
  localparam int NUM_REQ = 2;
  localparam int RW      = 2*W + 2;   // radicand
  localparam int MW      = W + 3;     // stored remainder
  localparam int TW      = W + 5;     // shifted remainder / trial compare
  localparam int CW      = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SQUARE, S_ITER, S_DONE} state_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } op_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            id_q, id_d;
  op_t             op_q, op_d;
  logic [RW-1:0]   rad_q, rad_d;
  logic [MW-1:0]   rem_q, rem_d;
  logic [W:0]      root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic                            idle;
  logic                            gnt_id;
  logic                            accept;
  logic [NUM_REQ-1:0][W-1:0]       xs, ys;
  logic [NUM_REQ-1:0][2*W-1:0]     ops;
  op_t                             op_sel;
  logic [TW-1:0]                   rem_sh;
  logic [TW-1:0]                   trial;

  assign idle = (state_q == S_IDLE);
  assign xs   = {req_x1, req_x0};
  assign ys   = {req_y1, req_y0};

  // Round robin: the pointer-selected requester wins if it is asking,
  // otherwise the other one. Ready is only raised for a valid grantee.
  assign gnt_id = req_valid[ptr_q] ? ptr_q : ~ptr_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    hypot_sched_port #(.W(W), .IDX(i)) u_port (
      .idle_i   (idle),
      .valid_i  (req_valid[i]),
      .gnt_id_i (gnt_id),
      .x_i      (xs[i]),
      .y_i      (ys[i]),
      .ready_o  (req_ready[i]),
      .op_o     (ops[i])
    );
  end

  assign accept = |(req_valid & req_ready);
  assign op_sel = op_t'(ops[gnt_id]);

  // One restoring-sqrt step: bring down the next two radicand bits and
  // test against 4*root+1. The shifted remainder needs two extra bits
  // beyond the stored remainder before the subtract brings it back down.
  assign rem_sh = {rem_q, rad_q[RW-1 -: 2]};
  assign trial  = {2'b00, root_q, 2'b01};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_sel;
          id_d    = gnt_id;
          ptr_d   = ~gnt_id;
          state_d = S_SQUARE;
        end
      end
      S_SQUARE: begin
        rad_d   = RW'(op_q.x) * RW'(op_q.x) + RW'(op_q.y) * RW'(op_q.y);
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = CW'(W);
        state_d = S_ITER;
      end
      S_ITER: begin
        if (rem_sh >= trial) begin
          rem_d  = MW'(rem_sh - trial);
          root_d = {root_q[W-1:0], 1'b1};
        end else begin
          rem_d  = MW'(rem_sh);
          root_d = {root_q[W-1:0], 1'b0};
        end
        rad_d = {rad_q[RW-3:0], 2'b00};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  // root/rem are frozen in DONE, so the response holds under backpressure.
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_root  = root_q;
  assign rsp_exact = (state_q == S_DONE) && (rem_q == '0);
  assign rsp_id    = id_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_hypot_sched.sv
module tb_hypot_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [W-1:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W:0]   rsp_root;
  logic         rsp_exact, rsp_id, busy;

  hypot_sched #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x0    (req_x0),
    .req_y0    (req_y0),
    .req_x1    (req_x1),
    .req_y1    (req_y1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_root  (rsp_root),
    .rsp_exact (rsp_exact),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y;} op_t;
  typedef struct {int id; int root; int exact;} exp_t;

  op_t  q0[$], q1[$];
  exp_t sb[$];

  int n_cmp = 0, n_err = 0;
  bit [1:0] acc_pend = '0;
  int acc_cnt = 0, acc_cyc = 0, last_acc = -1;
  bit chk_alt = 0;
  int exp_alt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: largest r with r*r <= x^2+y^2, found by plain counting.
  function automatic void ref_hyp(input int x, input int y, output int r, output int ex);
    int s;
    s = x*x + y*y;
    r = 0;
    while ((r+1)*(r+1) <= s) r++;
    ex = (r*r == s) ? 1 : 0;
  endfunction

  task automatic push(input int p, input int x, input int y);
    op_t o;
    o.x = x; o.y = y;
    if (p == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  // Request drivers: each port presents the head of its queue; an idle
  // port shows random junk operands that must be ignored.
  initial forever begin
    @(posedge clk); #1;
    if (acc_pend[0]) begin q0.delete(0); acc_pend[0] = 1'b0; end
    if (acc_pend[1]) begin q1.delete(0); acc_pend[1] = 1'b0; end
    if (q0.size() > 0) begin
      req_valid[0] = 1'b1; req_x0 = 8'(q0[0].x); req_y0 = 8'(q0[0].y);
    end else begin
      req_valid[0] = 1'b0; req_x0 = 8'($urandom); req_y0 = 8'($urandom);
    end
    if (q1.size() > 0) begin
      req_valid[1] = 1'b1; req_x1 = 8'(q1[0].x); req_y1 = 8'(q1[0].y);
    end else begin
      req_valid[1] = 1'b0; req_x1 = 8'($urandom); req_y1 = 8'($urandom);
    end
  end

  // Monitor / scoreboard
  logic         prev_vld = 0, prev_rdy = 0, prev_ex = 0, prev_id = 0;
  logic [W:0]   prev_root = '0;
  bit           prev_acc = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_vld = 0; prev_rdy = 0; prev_acc = 0;
    end else begin
      check("ready_grant", ((req_ready & ~req_valid) == 2'b00) && ($countones(req_ready) <= 1), 1);
      if (rsp_valid) check("ready_while_rsp", req_ready, 0);
      if (prev_acc) check("busy_after_accept", busy, 1);
      if (prev_vld && !prev_rdy) begin
        check("hold_valid", rsp_valid, 1);
        check("hold_root", rsp_root, prev_root);
        check("hold_exact", rsp_exact, prev_ex);
        check("hold_id", rsp_id, prev_id);
      end
      if (rsp_valid && !prev_vld) check("latency", cyc - acc_cyc, W + 3);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got root %0d id %0d expected none", rsp_root, rsp_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_root", rsp_root, e.root);
          check("rsp_exact", rsp_exact, e.exact);
          check("rsp_id", rsp_id, e.id);
        end
      end
      prev_acc = 0;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          op_t  o;
          exp_t e;
          if (i == 0) o = q0[0]; else o = q1[0];
          ref_hyp(o.x, o.y, e.root, e.exact);
          e.id = i;
          sb.push_back(e);
          acc_pend[i] = 1'b1;
          if (chk_alt) begin
            check("alt_id", i, exp_alt);
            exp_alt ^= 1;
            if (last_acc >= 0) check("accept_spacing", cyc - last_acc, W + 4);
          end
          last_acc = cyc;
          acc_cyc  = cyc;
          acc_cnt++;
          prev_acc = 1;
        end
      end
      prev_vld = rsp_valid; prev_rdy = rsp_ready;
      prev_root = rsp_root; prev_ex = rsp_exact; prev_id = rsp_id;
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while (q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || busy || req_valid != 2'b00) begin
      @(negedge clk);
      n++;
      if (n > maxc) begin
        n_cmp++; n_err++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size() + q0.size() + q1.size());
        return;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_root"}, rsp_root, 0);
    check({tag, "_rsp_exact"}, rsp_exact, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_req_ready"}, req_ready, 0);
  endtask

  initial begin
    int n, a0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed corner operands
    push(0, 3, 4);     drain(100);
    push(1, 255, 255); drain(100);
    push(0, 0, 0);     drain(100);
    push(1, 1, 1);     drain(100);
    push(0, 255, 0);   drain(100);

    // Contention from reset: strict alternation starting with requester 0
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    last_acc = -1; exp_alt = 0; chk_alt = 1;
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin push(0, 6, 8); push(1, 5, 12); end
    drain(300);
    chk_alt = 0;

    // Backpressure in DONE with a pending request on the other port
    @(posedge clk); #2 rsp_ready = 1'b0; push(0, 7, 24);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_reached_done", rsp_valid, 1);
    @(posedge clk); #2 push(1, 20, 21);
    repeat (20) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_busy", busy, 0);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_grant", req_ready, 2'b10);
    drain(100);

    // Reset while iterating: discard the in-flight request
    a0 = acc_cnt;
    @(posedge clk); #2 push(1, 100, 200);
    n = 0;
    while (acc_cnt == a0 && n < 50) begin @(negedge clk); n++; end
    check("midreset_accepted", acc_cnt - a0, 1);
    repeat (6) @(posedge clk);
    check("midreset_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push(0, 9, 12); drain(100);

    // Randomised sweep with random backpressure
    push(0, 255, 255); push(1, 0, 255); push(1, 128, 128); push(0, 1, 0);
    repeat (3000) begin
      @(posedge clk); #2;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, 1);
        if ((p == 0 && q0.size() < 3) || (p == 1 && q1.size() < 3))
          push(p, $urandom_range(0, 255), $urandom_range(0, 255));
      end
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by 2000000");
    $fatal(1, "watchdog");
  end

endmodule
